// File: rtl/dsram_responder.sv
// Data-side SRAM responder: word RAM with byte-lane writes, MMIO counter/scratch/error block,
// fixed READ_LAT read pipeline. Define DSRAM_PARITY_EN to add per-byte even parity checking.
module dsram_responder #(
    parameter int unsigned MEM_WORDS_LOG2 = 12,
    parameter logic [31:0] RAM_BASE       = 32'h1C00_0000,
    parameter logic [31:0] MMIO_BASE      = 32'hBFAF_0000,
    parameter int unsigned READ_LAT       = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic        parity_err
);

    localparam int unsigned AW   = MEM_WORDS_LOG2;
    localparam int unsigned LAST = READ_LAT - 1;

    logic [31:0] mem [2**AW];

    logic [AW-1:0] widx;
    logic [7:0]    off;
    logic          ram_hit;
    logic          mmio_hit;
    logic          ram_acc;
    logic          mmio_acc;
    logic          miss;
    logic [31:0]   rd_word;
    logic          rd_perr;

    logic [31:0]   counter;
    logic [31:0]   scratch;
    logic          addr_err_q;
    logic          par_err_q;
    logic          clr0;
    logic          clr1;

    logic [31:0]         pd [READ_LAT];
    logic [READ_LAT-1:0] pv;
    logic [READ_LAT-1:0] pp;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^data_sram_addr[1:0];

    assign widx     = data_sram_addr[AW+1:2];
    assign off      = data_sram_addr[7:0];
    assign ram_hit  = data_sram_addr[31:AW+2] == RAM_BASE[31:AW+2];
    assign mmio_hit = data_sram_addr[31:8] == MMIO_BASE[31:8];
    assign ram_acc  = data_sram_en && ram_hit;
    assign mmio_acc = data_sram_en && mmio_hit && !ram_hit;
    assign miss     = data_sram_en && !ram_hit && !mmio_hit;

    // Write-1-to-clear only counts through byte lane 0, where both status bits live
    assign clr0 = mmio_acc && off == 8'h08 && data_sram_we[0] && data_sram_wdata[0];
    assign clr1 = mmio_acc && off == 8'h08 && data_sram_we[0] && data_sram_wdata[1];

`ifdef DSRAM_PARITY_EN
    logic [3:0] par_mem [2**AW];
    logic [3:0] par_rd;

    always_ff @(posedge clk) begin
        if (ram_acc) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    par_mem[widx][i] <= ^data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        par_rd = par_mem[widx];
        rd_perr = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if ((^mem[widx][8*i +: 8]) != par_rd[i]) begin
                rd_perr = ram_acc;
            end
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (ram_acc) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    mem[widx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            counter    <= '0;
            scratch    <= '0;
            addr_err_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            counter <= counter + 32'd1;
            if (mmio_acc && off == 8'h04) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (data_sram_we[i]) begin
                        scratch[8*i +: 8] <= data_sram_wdata[8*i +: 8];
                    end
                end
            end
            // Set dominates a simultaneous clear
            addr_err_q <= miss | (addr_err_q & ~clr0);
            par_err_q  <= rd_perr | (par_err_q & ~clr1);
        end
    end

    // Read-first: the word sampled here is the pre-write value for a write request
    always_comb begin
        rd_word = '0;
        if (ram_hit) begin
            rd_word = mem[widx];
        end else if (mmio_hit) begin
            case (off)
                8'h00:   rd_word = counter;
                8'h04:   rd_word = scratch;
                8'h08:   rd_word = {30'd0, par_err_q, addr_err_q};
                default: rd_word = '0;
            endcase
        end
    end

    // Data stages only load behind a valid bit, so the output holds between responses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pv <= '0;
            pp <= '0;
            for (int unsigned k = 0; k < READ_LAT; k++) begin
                pd[k] <= '0;
            end
        end else begin
            pv[0] <= data_sram_en;
            pp[0] <= rd_perr;
            if (data_sram_en) begin
                pd[0] <= rd_word;
            end
            for (int unsigned k = 1; k < READ_LAT; k++) begin
                pv[k] <= pv[k-1];
                pp[k] <= pp[k-1];
                if (pv[k-1]) begin
                    pd[k] <= pd[k-1];
                end
            end
        end
    end

    assign data_sram_rdata = pd[LAST];
    assign rdata_valid     = pv[LAST];
    assign parity_err      = pp[LAST] & pv[LAST];
    assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Scoreboard bench for dsram_responder (READ_LAT=3); parity checks compile in with DSRAM_PARITY_EN.
module tb_dsram_responder;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  we = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        addr_err;
    logic        parity_err;

    typedef struct {
        logic [31:0] data;
        bit          chk;
        bit          perr;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned tick = 0;
    logic [31:0] cnt_m = '0;
    int          checks = 0;
    int          errors = 0;
    int          valid_seen = 0;

    dsram_responder #(.READ_LAT(LAT)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .rdata_valid     (rdata_valid),
        .addr_err        (addr_err),
        .parity_err      (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick  <= tick + 1;
        cnt_m <= resetn ? cnt_m + 32'd1 : 32'd0;
    end

    // Monitor: pops one expectation per valid response; overdue entries are failures
    always @(posedge clk) begin
        #1;
        if (rdata_valid) valid_seen++;
        while (exp_q.size() > 0 && exp_q[0].due < tick) begin
            checks++;
            errors++;
            $display("FAIL missing_response due=%0d now=%0d no rdata_valid, expected data %h",
                     exp_q[0].due, tick, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        if (rdata_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid rdata=%h, expected no response", rdata);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (tick != mon_e.due) begin
                    errors++;
                    $display("FAIL latency got tick %0d, expected %0d", tick, mon_e.due);
                end
                if (mon_e.chk) begin
                    checks++;
                    if (rdata !== mon_e.data) begin
                        errors++;
                        $display("FAIL rdata got %h, expected %h", rdata, mon_e.data);
                    end
                end
                checks++;
                if (parity_err !== mon_e.perr) begin
                    errors++;
                    $display("FAIL parity_err got %b, expected %b", parity_err, mon_e.perr);
                end
            end
        end
    end

    task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                       input bit chk, input logic [31:0] d, input bit pe = 1'b0,
                       input bit cnt_rd = 1'b0);
        exp_t e;
        @(negedge clk);
        en = 1'b1;
        we = w;
        addr = a;
        wdata = wd;
        e.data = cnt_rd ? cnt_m : d;
        e.chk  = chk;
        e.perr = pe;
        e.due  = tick + LAT;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b0;
            we = '0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_valid", {31'd0, rdata_valid}, 32'h0);
        chk("reset_addr_err", {31'd0, addr_err}, 32'h0);
        chk("reset_parity_err", {31'd0, parity_err}, 32'h0);
        resetn = 1'b1;

        // Full-word write then immediate read of the same word
        req(4'hF, 32'h1C00_0010, 32'hDEAD_BEEF, 0, '0);
        req(4'h0, 32'h1C00_0010, '0, 1, 32'hDEAD_BEEF);
        idle(1);

        // Byte-lane writes; write responses return the old word
        req(4'hF, 32'h1C00_0020, 32'h1122_3344, 0, '0);
        req(4'b0100, 32'h1C00_0020, 32'hAAAA_AAAA, 1, 32'h1122_3344);
        req(4'h0, 32'h1C00_0020, '0, 1, 32'h11AA_3344);
        req(4'b0011, 32'h1C00_0020, 32'h5566_5566, 1, 32'h11AA_3344);
        req(4'h0, 32'h1C00_0020, '0, 1, 32'h11AA_5566);
        idle(LAT + 2);
        chk("hold_rdata", rdata, 32'h11AA_5566);
        chk("hold_valid", {31'd0, rdata_valid}, 32'h0);

        // Back-to-back reads
        req(4'hF, 32'h1C00_0000, 32'd1, 0, '0);
        req(4'hF, 32'h1C00_0004, 32'd2, 0, '0);
        req(4'hF, 32'h1C00_0008, 32'd3, 0, '0);
        req(4'h0, 32'h1C00_0000, '0, 1, 32'd1);
        req(4'h0, 32'h1C00_0004, '0, 1, 32'd2);
        req(4'h0, 32'h1C00_0008, '0, 1, 32'd3);
        idle(2);

        // MMIO counter, scratch, unmapped offset
        req(4'h0, 32'hBFAF_0000, '0, 1, '0, 0, 1);
        idle(4);
        req(4'h0, 32'hBFAF_0000, '0, 1, '0, 0, 1);
        req(4'hF, 32'hBFAF_0004, 32'hCAFE_F00D, 1, 32'h0);
        req(4'h0, 32'hBFAF_0004, '0, 1, 32'hCAFE_F00D);
        req(4'b1000, 32'hBFAF_0004, 32'h1234_5678, 1, 32'hCAFE_F00D);
        req(4'h0, 32'hBFAF_0004, '0, 1, 32'h12FE_F00D);
        req(4'hF, 32'hBFAF_000C, 32'hFFFF_FFFF, 1, 32'h0);
        req(4'h0, 32'hBFAF_000C, '0, 1, 32'h0);
        idle(1);
        chk("no_err_mmio", {31'd0, addr_err}, 32'h0);

        // Miss handling and write-1-to-clear
        req(4'hF, 32'h0000_1000, 32'h1234_5678, 1, 32'h0);
        idle(1);
        chk("miss_sets_addr_err", {31'd0, addr_err}, 32'h1);
        req(4'h0, 32'hBFAF_0008, '0, 1, 32'h1);
        req(4'hF, 32'hBFAF_0008, 32'h1, 1, 32'h1);
        idle(1);
        chk("w1c_clears", {31'd0, addr_err}, 32'h0);
        req(4'h0, 32'h2000_0000, '0, 1, 32'h0);
        req(4'hF, 32'hBFAF_0008, 32'h0, 1, 32'h1);
        idle(1);
        chk("write0_keeps", {31'd0, addr_err}, 32'h1);
        req(4'b1110, 32'hBFAF_0008, 32'hFFFF_FFFF, 1, 32'h1);
        idle(1);
        chk("lane0_off_keeps", {31'd0, addr_err}, 32'h1);
        req(4'hF, 32'hBFAF_0008, 32'h3, 1, 32'h1);
        idle(1);
        chk("final_clear", {31'd0, addr_err}, 32'h0);

`ifdef DSRAM_PARITY_EN
        req(4'hF, 32'h1C00_0040, 32'h0F0F_0F0F, 0, '0);
        idle(LAT + 1);
        dut.par_mem[16][0] = ~dut.par_mem[16][0];
        req(4'h0, 32'h1C00_0040, '0, 1, 32'h0F0F_0F0F, 1);
        req(4'h0, 32'h1C00_0010, '0, 1, 32'hDEAD_BEEF, 0);
        idle(LAT + 1);
        req(4'h0, 32'hBFAF_0008, '0, 1, 32'h2);
        req(4'hF, 32'hBFAF_0008, 32'h2, 1, 32'h2);
        req(4'h0, 32'hBFAF_0008, '0, 1, 32'h0);
        idle(1);
`endif

        // Reset with reads in flight: only the first response precedes reset
        req(4'h0, 32'h1C00_0000, '0, 1, 32'd1);
        req(4'h0, 32'h1C00_0004, '0, 1, 32'd2);
        req(4'h0, 32'h1C00_0008, '0, 1, 32'd3);
        @(negedge clk);
        en = 1'b0;
        resetn = 1'b0;
        exp_q.delete();
        valid_seen = 0;
        idle(2);
        resetn = 1'b1;
        idle(8);
        chk("no_valid_after_reset", valid_seen, 32'd0);
        chk("rdata_after_reset", rdata, 32'h0);
        req(4'h0, 32'h1C00_0010, '0, 1, 32'hDEAD_BEEF);
        req(4'h0, 32'hBFAF_0000, '0, 1, '0, 0, 1);
        idle(LAT + 3);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
